boot_rom_loader: RTL and testbench
==================================

# boot_rom_loader

Sequences ROM image downloads from the HPS ioctl stream into SDRAM and arbitrates the single SDRAM command port between the loader and the CPC motherboard. Each 16 KB download page is mapped to a fixed SDRAM ROM bank. Writes are paced to the SDRAM refresh/clock-enable slot with an ioctl_wait handshake. The block holds the machine in reset until the last byte has been committed.

## Interface
Parameters:
- PAGE0, 9'h000: SDRAM addr[22:14] for download page 0 (OS ROM).
- PAGE1, 9'h100: bank for page 1 (BASIC).
- PAGE2, 9'h107: bank for page 2 (AMSDOS).
- TAIL_CYCLES, 64: clk_sys cycles machine reset is held after the download ends and the loader is idle.

Ports (clock and reset first):
- clk_sys  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- ce_ref  in  1  SDRAM slot strobe, one cycle wide.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download target; 0 = ROM.
- ioctl_wr  in  1  byte strobe, one cycle wide.
- ioctl_addr  in  25  byte offset.
- ioctl_dout  in  8  byte value.
- ioctl_wait  out  1  stalls the HPS stream.
- cpu_r, cpu_w  in  1 each  motherboard read and write requests.
- cpu_a  in  23  motherboard address.
- cpu_din  in  8  motherboard write data.
- mem_oe, mem_we  out  1 each  to the SDRAM controller.
- mem_a  out  23  to the SDRAM controller.
- mem_din  out  8  to the SDRAM controller.
- rom_mask  out  8  0x00 when cpu_a is in a ROM bank, else 0xFF.
- machine_reset  out  1  reset request to the motherboard.
- drop_cnt  out  8  count of bytes whose page is unmapped (saturating).
- overrun  out  1  sticky flag; an ioctl_wr arrived while busy.
- checksum  out  16  present only when compiled in (see Configuration).

## Operation
- rom_dl = ioctl_download & (ioctl_index == 0).
- FSM states:
  - IDLE
    - On ioctl_wr & rom_dl with page = ioctl_addr[24:14] in {0,1,2}: latch data and address, where addr = {PAGEn, ioctl_addr[13:0]}. Set ioctl_wait=1 and go to ARM.
    - Page ≥ 3: discard the byte, increment drop_cnt (saturate at 255), keep ioctl_wait=0, stay in IDLE.
  - ARM: on ce_ref, set mem_we_l=1 and go to WRITE.
  - WRITE: on ce_ref, clear mem_we_l, clear ioctl_wait, and go to IDLE.
- ioctl_wr in ARM or WRITE: ignore the strobe and set overrun (cleared only by reset).
- ioctl_download falling mid-write: the in-flight write still completes.
- machine_reset = rom_dl | (FSM ≠ IDLE) | (tail counter ≠ 0).
  - The tail counter loads TAIL_CYCLES on each cycle where rom_dl | FSM≠IDLE, and decrements to 0 otherwise.
- Port mux, selected by machine_reset:
  - Loader owns the port: mem_oe=0, mem_we=mem_we_l, mem_a and mem_din = latched values.
  - Otherwise the cpu_* signals pass through combinationally.
- rom_mask = 0x00 if cpu_a[22:22]==0 (banks 0x000–0x0FF) or cpu_a[22:14] ∈ {PAGE1, PAGE2}; else 0xFF. It is purely combinational.
- Non-ROM downloads (ioctl_index≠0) are never acknowledged or stalled and do not assert machine_reset.

## Timing
- Reset values:
  - ioctl_wait, mem_we_l, overrun = 0.
  - drop_cnt = 0, checksum = 0.
  - FSM = IDLE.
  - tail counter = TAIL_CYCLES, so machine_reset=1 for TAIL_CYCLES cycles after reset release.
- ioctl_wait rises on the cycle after ioctl_wr.
- mem_we is high from the cycle after the first ce_ref that follows the latch, until the cycle after the next ce_ref. That is exactly one ce_ref period.
- Worst-case byte latency is 2 ce_ref periods plus 1 cycle (about 33 clk_sys cycles with a 16-cycle ce_ref).
- ioctl_wr coincident with the latch cycle's ce_ref: ARM waits for the next ce_ref and does not use the coincident one.
- Asynchronous reset mid-write: the FSM returns to IDLE and mem_we drops immediately. The partial byte is not retried.
- Port handover: the loader releases the port only after the tail counter expires, so the CPU never sees a half-written cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - checksum is the 16-bit wrapping sum of every byte actually written.
  - It clears on the rising edge of rom_dl.
  - It is stable whenever machine_reset=0.
- LOADER_CHECKSUM_EN undefined: the checksum port and adder are absent.

## Test plan
- Page mapping: ROM download of 3 bytes at ioctl_addr 0x0000, 0x4005, 0x8010 with values 0x11/0x22/0x33 → mem_we writes at 0x000000, 0x400005, 0x41C010; drop_cnt=0; checksum=0x0066.
- Dropped page: byte at ioctl_addr 0xC000 → no mem_we, ioctl_wait stays 0, drop_cnt=1. After 300 such bytes drop_cnt=255.
- Handshake: ce_ref every 16 cycles, ioctl_wr at cycle 0 → ioctl_wait 1 at cycle 1. mem_we spans exactly one ce_ref period. ioctl_wait falls the cycle after the second ce_ref.
- Overrun and tail: second ioctl_wr issued while in ARM → overrun=1 and no extra write. After the download drops, machine_reset falls exactly TAIL_CYCLES cycles after the FSM reaches IDLE, and cpu_* then appear on mem_*.
- Reset mid-write: assert reset while mem_we=1 → mem_we, ioctl_wait, and overrun all 0 in the same cycle; machine_reset=1 for 64 cycles after release.
- rom_mask: cpu_a 0x040000 → 0x00; 0x41C000 → 0x00; 0x404000 → 0xFF.

Source files
------------

// File: rtl/boot_rom_loader.sv
// ROM download sequencer: maps HPS ioctl pages onto SDRAM ROM banks, paces writes to ce_ref,
// and shares the SDRAM command port with the motherboard. Optional checksum: LOADER_CHECKSUM_EN.
module boot_rom_loader #(
  parameter logic [8:0]  PAGE0       = 9'h000,
  parameter logic [8:0]  PAGE1       = 9'h100,
  parameter logic [8:0]  PAGE2       = 9'h107,
  parameter int unsigned TAIL_CYCLES = 64
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_ref,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        cpu_r,
  input  logic        cpu_w,
  input  logic [22:0] cpu_a,
  input  logic [7:0]  cpu_din,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [22:0] mem_a,
  output logic [7:0]  mem_din,
  output logic [7:0]  rom_mask,
  output logic        machine_reset,
  output logic [7:0]  drop_cnt,
  output logic        overrun
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, ARM, WRITE} state_t;

  localparam logic [15:0] TAIL_LOAD = 16'(TAIL_CYCLES);

  state_t      state_q, state_d;
  logic        wait_q, wait_d;
  logic        we_l_q, we_l_d;
  logic [22:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  drop_q, drop_d;
  logic        overrun_q, overrun_d;
  logic [15:0] tail_q, tail_d;

  logic        rom_dl;
  logic        busy;
  logic        page_hit;
  logic [8:0]  page_bank;

  assign rom_dl = ioctl_download & (ioctl_index == 8'd0);
  assign busy   = rom_dl | (state_q != IDLE);

  always_comb begin
    page_hit  = 1'b1;
    page_bank = PAGE0;
    case (ioctl_addr[24:14])
      11'd0:   page_bank = PAGE0;
      11'd1:   page_bank = PAGE1;
      11'd2:   page_bank = PAGE2;
      default: page_hit  = 1'b0;
    endcase
  end

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    we_l_d    = we_l_q;
    addr_d    = addr_q;
    data_d    = data_q;
    drop_d    = drop_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (ioctl_wr && rom_dl) begin
          if (page_hit) begin
            addr_d  = {page_bank, ioctl_addr[13:0]};
            data_d  = ioctl_dout;
            wait_d  = 1'b1;
            state_d = ARM;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      ARM: begin
        if (ioctl_wr) overrun_d = 1'b1;
        if (ce_ref) begin
          we_l_d  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (ioctl_wr) overrun_d = 1'b1;
        if (ce_ref) begin
          we_l_d  = 1'b0;
          wait_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tail counter reloads while the loader is active so the port is only released once it expires.
  always_comb begin
    if (busy)                tail_d = TAIL_LOAD;
    else if (tail_q != '0)   tail_d = tail_q - 16'd1;
    else                     tail_d = tail_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= 1'b0;
      we_l_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      drop_q    <= '0;
      overrun_q <= 1'b0;
      tail_q    <= TAIL_LOAD;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      we_l_q    <= we_l_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      drop_q    <= drop_d;
      overrun_q <= overrun_d;
      tail_q    <= tail_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic        rom_dl_q;
  logic [15:0] csum_q, csum_d;

  // Sum is taken when the write slot closes, so it never moves while the CPU owns the port.
  always_comb begin
    csum_d = csum_q;
    if (rom_dl && !rom_dl_q)              csum_d = '0;
    else if (state_q == WRITE && ce_ref)  csum_d = csum_q + {8'h00, data_q};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_dl_q <= 1'b0;
      csum_q   <= '0;
    end else begin
      rom_dl_q <= rom_dl;
      csum_q   <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

  assign machine_reset = busy | (tail_q != '0);
  assign ioctl_wait    = wait_q;
  assign drop_cnt      = drop_q;
  assign overrun       = overrun_q;

  assign mem_oe  = machine_reset ? 1'b0   : cpu_r;
  assign mem_we  = machine_reset ? we_l_q : cpu_w;
  assign mem_a   = machine_reset ? addr_q : cpu_a;
  assign mem_din = machine_reset ? data_q : cpu_din;

  assign rom_mask = (!cpu_a[22] || cpu_a[22:14] == PAGE1 || cpu_a[22:14] == PAGE2) ? 8'h00 : 8'hFF;

endmodule

// File: tb/tb_boot_rom_loader.sv
// Scoreboard bench for boot_rom_loader: stimulus pushes expected SDRAM writes, a monitor pops
// and compares on each loader mem_we pulse. Define LOADER_CHECKSUM_EN to also check the checksum.
module tb_boot_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_ref;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        cpu_r, cpu_w;
  logic [22:0] cpu_a;
  logic [7:0]  cpu_din;
  logic        mem_oe, mem_we;
  logic [22:0] mem_a;
  logic [7:0]  mem_din;
  logic [7:0]  rom_mask;
  logic        machine_reset;
  logic [7:0]  drop_cnt;
  logic        overrun;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  boot_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_a(cpu_a), .cpu_din(cpu_din),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_a(mem_a), .mem_din(mem_din),
    .rom_mask(rom_mask), .machine_reset(machine_reset), .drop_cnt(drop_cnt),
    .overrun(overrun)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial forever #5 clk_sys = ~clk_sys;

  typedef struct { logic [22:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          drop_model = 0;
  logic [15:0] csum_model = '0;
  bit          skip_width = 1'b0;
  int          ce_cnt = 0;

  logic [8:0] bank_tab [3] = '{9'h000, 9'h100, 9'h107};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] map_addr(input logic [24:0] a, output bit ok);
    int pg;
    pg = int'(a[24:14]);
    ok = (pg < 3);
    return ok ? {bank_tab[pg], a[13:0]} : 23'h0;
  endfunction

  function automatic logic [7:0] mask_model(input logic [22:0] a);
    int bank;
    bank = int'(a[22:14]);
    return (bank < 256 || bank == 'h100 || bank == 'h107) ? 8'h00 : 8'hFF;
  endfunction

  // ce_ref: one-cycle strobe every 16 clocks
  initial begin
    ce_ref = 1'b0;
    forever begin
      @(negedge clk_sys);
      ce_ref = (ce_cnt == 0);
      ce_cnt = (ce_cnt + 1) % 16;
    end
  end

  // Monitor: one scoreboard pop per loader write pulse, pulse width must be one ce_ref period
  bit prev_we = 1'b0;
  int width = 0;
  always @(negedge clk_sys) begin
    bit lw;
    wr_t e;
    lw = mem_we && machine_reset;
    if (lw && !prev_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_a), 32'(e.a));
        check("write_data", 32'(mem_din), 32'(e.d));
        check("write_oe_low", 32'(mem_oe), 0);
      end
      width = 1;
    end else if (lw) begin
      width++;
    end else if (prev_we && !skip_width) begin
      check("we_width", width, 16);
    end
    prev_we = lw;
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, output bit accepted);
    bit ok;
    logic [22:0] ma;
    ma = map_addr(a, ok);
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    accepted = ioctl_download && ioctl_index == 8'd0 && ok;
    if (accepted) begin
      exp_q.push_back('{ma, d});
      csum_model += 16'(d);
      check("wait_rise", 32'(ioctl_wait), 1);
    end else begin
      if (ioctl_download && ioctl_index == 8'd0) drop_model = (drop_model < 255) ? drop_model + 1 : 255;
      check("wait_stays_low", 32'(ioctl_wait), 0);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (ioctl_wait && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    if (ioctl_wait) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic count_reset(output int n);
    n = 0;
    while (machine_reset && n < 300) begin
      n++;
      @(negedge clk_sys);
    end
  endtask

  task automatic start_rom_dl();
    @(negedge clk_sys);
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    csum_model = '0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    logic [31:0] r;
    logic [10:0] pg;

    reset = 1'b1; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
    ioctl_addr = 0; ioctl_dout = 0; cpu_r = 0; cpu_w = 0; cpu_a = 0; cpu_din = 0;
    repeat (3) @(negedge clk_sys);
    check("rst_wait", 32'(ioctl_wait), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_mreset", 32'(machine_reset), 1);
`ifdef LOADER_CHECKSUM_EN
    check("rst_csum", 32'(checksum), 0);
`endif
    reset = 1'b0;
    count_reset(n);
    check("tail_after_reset", n, 64);

    // rom_mask: fixed corners then random addresses
    cpu_a = 23'h040000; #1 check("mask_040000", 32'(rom_mask), 32'h00);
    cpu_a = 23'h41C000; #1 check("mask_41C000", 32'(rom_mask), 32'h00);
    cpu_a = 23'h404000; #1 check("mask_404000", 32'(rom_mask), 32'hFF);
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      cpu_a = r[22:0];
      #1 check("mask_rand", 32'(rom_mask), 32'(mask_model(cpu_a)));
    end
    cpu_a = 0;

    // page mapping
    start_rom_dl();
    send_byte(25'h0000000, 8'h11, acc); wait_idle(n);
    send_byte(25'h0004005, 8'h22, acc); wait_idle(n);
    send_byte(25'h0008010, 8'h33, acc); wait_idle(n);
    check("map_queue_empty", exp_q.size(), 0);
    check("map_drop", 32'(drop_cnt), 0);
`ifdef LOADER_CHECKSUM_EN
    check("map_csum", 32'(checksum), 32'h0066);
`endif

    // dropped page
    send_byte(25'h000C000, 8'h44, acc);
    @(negedge clk_sys);
    check("drop_wait_low", 32'(ioctl_wait), 0);
    check("drop_one", 32'(drop_cnt), 1);

    // ce_ref coincident with the latch edge: ARM must wait for the next strobe
    n = 0;
    do begin @(posedge clk_sys); n++; end while (!ce_ref && n < 40);
    repeat (15) @(negedge clk_sys);
    send_byte(25'h0000123, 8'h5A, acc);
    wait_idle(n);
    check("coincident_latency", n, 32);

    // random traffic across mapped and unmapped pages
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      pg = 11'($urandom_range(0, 5));
      if (pg == 11'd5) pg = 11'h7FF;
      send_byte({pg, r[13:0]}, r[21:14], acc);
      if (acc) begin
        wait_idle(n);
        check("latency_range", 32'(n >= 17 && n <= 32), 1);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk_sys);
    end
    check("rand_drop", 32'(drop_cnt), 32'(drop_model));
`ifdef LOADER_CHECKSUM_EN
    check("rand_csum", 32'(checksum), 32'(csum_model));
`endif

    // drop saturation
    for (int i = 0; i < 300; i++) send_byte(25'h000C000 + 25'(i), 8'hEE, acc);
    @(negedge clk_sys);
    check("drop_saturate", 32'(drop_cnt), 32'(drop_model));
    check("drop_model_255", drop_model, 255);

    // overrun: second strobe while busy is ignored and flagged
    send_byte(25'h0004321, 8'hA5, acc);
    @(negedge clk_sys); ioctl_addr = 25'h0000777; ioctl_dout = 8'hFF; ioctl_wr = 1'b1;
    @(negedge clk_sys); ioctl_wr = 1'b0;
    check("overrun_set", 32'(overrun), 1);
    wait_idle(n);
    check("overrun_queue", exp_q.size(), 0);

    // download drops mid-write; write completes, then tail runs from IDLE
    send_byte(25'h0008ABC, 8'h3C, acc);
    ioctl_download = 1'b0;
    wait_idle(n);
    check("inflight_done", exp_q.size(), 0);
    count_reset(n);
    check("tail_after_idle", n, 64);
    check("overrun_sticky", 32'(overrun), 1);
`ifdef LOADER_CHECKSUM_EN
    check("final_csum", 32'(checksum), 32'(csum_model));
`endif

    // CPU pass-through once the loader has released the port
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      cpu_r = r[0]; cpu_w = r[1]; cpu_a = r[24:2]; cpu_din = r[31:24];
      #1;
      check("pass_oe", 32'(mem_oe), 32'(cpu_r));
      check("pass_we", 32'(mem_we), 32'(cpu_w));
      check("pass_a", 32'(mem_a), 32'(cpu_a));
      check("pass_din", 32'(mem_din), 32'(cpu_din));
      @(negedge clk_sys);
    end
    cpu_r = 0; cpu_w = 0; cpu_a = 0; cpu_din = 0;

    // non-ROM download: never stalled, no write, no reset
    @(negedge clk_sys); ioctl_index = 8'd1; ioctl_download = 1'b1;
    send_byte(25'h0000010, 8'h99, acc);
    @(negedge clk_sys);
    check("nonrom_wait", 32'(ioctl_wait), 0);
    check("nonrom_mreset", 32'(machine_reset), 0);
    check("nonrom_drop", 32'(drop_cnt), 32'(drop_model));
    ioctl_download = 1'b0;

    // asynchronous reset while mem_we is high
    start_rom_dl();
    send_byte(25'h0000200, 8'h77, acc);
    n = 0;
    while (!mem_we && n < 40) begin @(negedge clk_sys); n++; end
    check("reach_we", 32'(mem_we), 1);
    skip_width = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_mid_we", 32'(mem_we), 0);
    check("rst_mid_wait", 32'(ioctl_wait), 0);
    check("rst_mid_overrun", 32'(overrun), 0);
    check("rst_mid_drop", 32'(drop_cnt), 0);
    drop_model = 0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    count_reset(n);
    check("tail_after_rst_mid", n, 64);
    skip_width = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    check("rst_mid_csum", 32'(checksum), 0);
`endif

    repeat (40) @(negedge clk_sys);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_no_we", 32'(mem_we), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
